// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider.
// One shift-subtract step per cycle; results held until the next completion.
module seq_restoring_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state, state_nx;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] r;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH:0]   t;
   logic [WIDTH:0]   d;
   logic             accept;
   logic             last;

   assign accept = start && (state != RUN);
   assign last   = (cnt == '0);
   assign t      = {r, q[WIDTH-1]};
   assign d      = t - {1'b0, dvs};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = (divisor == '0) ? DONE : RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (last) state_nx = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) state_nx = (divisor == '0) ? DONE : RUN;
            else       state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Borrow (d[WIDTH]) means restore: keep t, shift in a 0 quotient bit.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         r           <= '0;
         q           <= '0;
         dvs         <= '0;
         quotient    <= '0;
         remainder   <= '0;
         div_by_zero <= 1'b0;
      end else if (accept) begin
         cnt <= CW'(WIDTH - 1);
         r   <= '0;
         q   <= dividend;
         dvs <= divisor;
         if (divisor == '0) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
         end
      end else if (state == RUN) begin
         r   <= d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
         q   <= {q[WIDTH-2:0], ~d[WIDTH]};
         cnt <= cnt - CW'(1);
         if (last) begin
            quotient    <= {q[WIDTH-2:0], ~d[WIDTH]};
            remainder   <= d[WIDTH] ? t[WIDTH-1:0] : d[WIDTH-1:0];
            div_by_zero <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider.
// Directed cases, then exhaustive and random ops against an arithmetic model.
module tb_seq_restoring_divider;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] dividend;
   logic [W-1:0] divisor;
   logic         busy;
   logic         done;
   logic [W-1:0] quotient;
   logic [W-1:0] remainder;
   logic         div_by_zero;

   int checks = 0;
   int errors = 0;

   seq_restoring_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pulse start for one edge; operands are scrambled after acceptance.
   task automatic issue(input int a, input int b);
      dividend = W'(a);
      divisor  = W'(b);
      start    = 1'b1;
      tick();
      start    = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
   endtask

   // Counts cycles from the accept edge until done, with a bound.
   task automatic wait_done(output int lat, output int bc);
      lat = 1;
      bc  = 0;
      while (!done && lat <= W + 3) begin
         if (busy) bc++;
         tick();
         lat++;
      end
   endtask

   task automatic expect_result(input string tag, input int a, input int b,
                                input int lat, input int bc);
      int eq, er, ez;
      ez = (b == 0);
      eq = ez ? (1 << W) - 1 : a / b;
      er = ez ? a : a % b;
      check({tag, ".done"}, int'(done), 1);
      check({tag, ".lat"}, lat, ez ? 1 : W + 1);
      check({tag, ".busy"}, bc, ez ? 0 : W);
      check({tag, ".q"}, int'(quotient), eq);
      check({tag, ".r"}, int'(remainder), er);
      check({tag, ".dbz"}, int'(div_by_zero), ez);
   endtask

   task automatic do_op(input string tag, input int a, input int b);
      int lat, bc;
      issue(a, b);
      wait_done(lat, bc);
      expect_result(tag, a, b, lat, bc);
   endtask

   // Full op followed by one idle cycle: done must drop, results hold.
   task automatic do_op_idle(input string tag, input int a, input int b);
      int pq, pr;
      do_op(tag, a, b);
      pq = int'(quotient);
      pr = int'(remainder);
      tick();
      check({tag, ".done_drop"}, int'(done), 0);
      check({tag, ".q_hold"}, int'(quotient), pq);
      check({tag, ".r_hold"}, int'(remainder), pr);
   endtask

   initial begin
      int lat, bc, seen;
      rst      = 1'b1;
      start    = 1'b1;
      dividend = 4'd9;
      divisor  = 4'd3;
      tick();
      tick();
      check("rst.busy", int'(busy), 0);
      check("rst.done", int'(done), 0);
      check("rst.q", int'(quotient), 0);
      check("rst.r", int'(remainder), 0);
      check("rst.dbz", int'(div_by_zero), 0);
      start = 1'b0;
      rst   = 1'b0;
      tick();

      do_op_idle("d13_3", 13, 3);
      do_op_idle("d15_1", 15, 1);
      do_op_idle("d5_7", 5, 7);
      do_op_idle("d15_15", 15, 15);
      do_op_idle("d9_0", 9, 0);
      do_op_idle("d6_2", 6, 2);

      // Re-pulse while busy must be ignored.
      issue(12, 5);
      tick();
      dividend = 4'd3;
      divisor  = 4'd1;
      start    = 1'b1;
      tick();
      start = 1'b0;
      wait_done(lat, bc);
      expect_result("ign12_5", 12, 5, lat + 2, bc + 2);
      // Back-to-back start on the done cycle.
      do_op_idle("b2b7_2", 7, 2);

      // Reset mid-division aborts without a done.
      issue(14, 3);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("abort.busy", int'(busy), 0);
      check("abort.done", int'(done), 0);
      check("abort.q", int'(quotient), 0);
      check("abort.r", int'(remainder), 0);
      seen = 0;
      for (int i = 0; i < W + 3; i++) begin
         if (done || busy) seen = 1;
         tick();
      end
      check("abort.quiet", seen, 0);

      for (int a = 0; a < (1 << W); a++)
         for (int b = 0; b < (1 << W); b++)
            do_op_idle($sformatf("ex%0d_%0d", a, b), a, b);

      // Random back-to-back chains, no idle gap between ops.
      for (int i = 0; i < 60; i++)
         do_op($sformatf("rnd%0d", i), int'($urandom_range(15)),
               int'($urandom_range(15)));
      tick();
      check("rnd.done_drop", int'(done), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
